// File: rtl/pdp8lxbrarb.sv
// Arbiter that shares one 32Kx12 block RAM between the PDP-8 memory-extension
// port (absolute priority, zero latency) and single-word ARM register accesses.
module pdp8lxbrarb #(
  parameter logic [11:0] VERSION = 12'h001
) (
  input  logic        CLOCK,
  input  logic        _RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [14:0] xbraddr,
  input  logic [11:0] xbrwdat,
  output logic [11:0] xbrrdat,
  input  logic        xbrenab,
  input  logic        xbrwena,
  output logic [14:0] ramaddr,
  output logic [11:0] ramwdat,
  input  logic [11:0] ramrdat,
  output logic        ramenab,
  output logic        ramwena
);

  typedef enum logic [1:0] {IDLE, PEND, CAPT} state_t;

  state_t      state, state_nxt;
  logic        wr;
  logic [11:0] wdata;
  logic [14:0] addr;
  logic [11:0] rdata;
  logic [7:0]  overruns;
  logic [7:0]  deferrals;
  logic [15:0] maxwait;
  logic [15:0] waitcnt;

  logic busy, armsel, start_req, start_ok, overrun, cnt_clr;
  logic unused_bits;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign busy        = (state != IDLE);
  assign armsel      = (state == PEND) && !xbrenab;
  assign start_req   = armwrite && (armwaddr == 2'd1) && armwdata[31];
  assign start_ok    = start_req && !busy;
  assign overrun     = start_req && busy;
  assign cnt_clr     = armwrite && (armwaddr == 2'd3);
  assign unused_bits = ^armwdata[17:15];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = PEND;
      PEND:    if (armsel)    state_nxt = CAPT;
      CAPT:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge _RESET) begin
    if (!_RESET) begin
      state <= IDLE;
      wr    <= 1'b0;
      wdata <= '0;
      addr  <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        wr    <= armwdata[30];
        wdata <= armwdata[29:18];
        addr  <= armwdata[14:0];
      end
      // RAM output during CAPT is the word addressed in the preceding PEND clock.
      if (state == CAPT && !wr) rdata <= ramrdat;
    end
  end

  always_ff @(posedge CLOCK or negedge _RESET) begin
    if (!_RESET) begin
      overruns  <= '0;
      deferrals <= '0;
      maxwait   <= '0;
      waitcnt   <= '0;
    end else begin
      if (cnt_clr)      overruns <= '0;
      else if (overrun) overruns <= sat_inc8(overruns);

      if (cnt_clr)                         deferrals <= '0;
      else if (state == PEND && xbrenab)   deferrals <= sat_inc8(deferrals);

      if (cnt_clr)                               maxwait <= '0;
      else if (armsel && waitcnt > maxwait)      maxwait <= waitcnt;

      if (start_ok)           waitcnt <= '0;
      else if (state == PEND) waitcnt <= sat_inc16(waitcnt);
    end
  end

  always_comb begin
    ramaddr = addr;
    ramwdat = wdata;
    ramenab = armsel;
    ramwena = armsel && wr;
    if (xbrenab) begin
      ramaddr = xbraddr;
      ramwdat = xbrwdat;
      ramenab = 1'b1;
      ramwena = xbrwena;
    end
  end

  assign xbrrdat = ramrdat;

  always_comb begin
    armrdata = '0;
    case (armraddr)
      2'd0: armrdata = {16'h5852, 4'h1, VERSION};
      2'd1: armrdata = {busy, wr, wdata, 3'b000, addr};
      2'd2: armrdata = {20'b0, rdata};
      2'd3: armrdata = {overruns, deferrals, maxwait};
      default: armrdata = '0;
    endcase
  end

endmodule

// File: doc/pdp8lxbrarb.md
PDP8LXBRARB -- requirements
Module: pdp8lxbrarb

Interface
REQ-001 Parameter VERSION, default 12'h001, version field returned in register 0 bits [11:00].
REQ-002 CLOCK  input  1  system clock; all state changes on rising edge.
REQ-003 _RESET  input  1  reset, asynchronous assertion, active-low.
REQ-004 armwrite  input  1  one-clock ARM register write strobe.
REQ-005 armraddr  input  2  ARM read register select.
REQ-006 armwaddr  input  2  ARM write register select.
REQ-007 armwdata  input  32  ARM write data.
REQ-008 armrdata  output  32  ARM read data, combinational from armraddr.
REQ-009 xbraddr  input  15  memory-extension port address {field, addr}.
REQ-010 xbrwdat  input  12  memory-extension port write data.
REQ-011 xbrrdat  output  12  memory-extension port read data.
REQ-012 xbrenab  input  1  memory-extension port chip enable.
REQ-013 xbrwena  input  1  memory-extension port write enable.
REQ-014 ramaddr  output  15  32Kx12 block RAM address.
REQ-015 ramwdat  output  12  block RAM write data.
REQ-016 ramrdat  input  12  block RAM read data, registered, 1-clock latency.
REQ-017 ramenab  output  1  block RAM enable.
REQ-018 ramwena  output  1  block RAM write enable.

Function
REQ-019 Registers: [0] read = {16'h5852 'XR', 4'h1, VERSION}; [1] ARM access; [2] read = {20'b0, rdata}; [3] read = {overruns[7:0], deferrals[7:0], maxwait[15:0]}.
REQ-020 Reg 1 read = {busy, wr, wdata[11:0], 3'b0, addr[14:0]}.
REQ-021 Reg 1 write with armwdata[31]=1 while IDLE: latch wr=[30], wdata=[29:18], addr=[14:0], go to PEND, busy=1 same edge.
REQ-022 Reg 1 write with armwdata[31]=0: no effect; write to regs 0 and 2: no effect.
REQ-023 Reg 1 start while PEND or CAPT: ignored, latched fields unchanged, overruns +1, saturating at 255.
REQ-024 States: IDLE, PEND, CAPT; busy = (state != IDLE).
REQ-025 armsel = (state == PEND) & ~xbrenab, combinational.
REQ-026 RAM mux: xbrenab=1 -> ramaddr/ramwdat/ramenab/ramwena = xbraddr/xbrwdat/1/xbrwena; else armsel=1 -> addr/wdata/1/wr; else ramenab=0, ramwena=0, ramaddr and ramwdat hold the ARM latched values.
REQ-027 Extension port has absolute priority; its signals pass through with zero added latency, never delayed or blocked.
REQ-028 xbrrdat = ramrdat, combinational pass-through.
REQ-029 PEND: armsel=1 -> CAPT next edge (ARM RAM access exactly one clock); xbrenab=1 -> stay PEND, deferrals +1 per blocked clock, saturating at 255.
REQ-030 waitcnt (16-bit, saturating) clears on entry to PEND, +1 per clock in PEND; on PEND->CAPT, maxwait <= max(maxwait, waitcnt).
REQ-031 CAPT: if wr=0, rdata <= ramrdat; if wr=1, rdata unchanged; -> IDLE next edge, busy=0.
REQ-032 CAPT is one clock regardless of xbrenab; extension access during CAPT does not affect captured data (RAM output at CAPT edge reflects ARM address).
REQ-033 Read completion latency with no contention: start edge N, RAM access clock N+1, rdata valid and busy=0 after edge N+2.
REQ-034 Any write to reg 3 clears overruns, deferrals, maxwait; clear wins over a simultaneous increment.

Reset
REQ-035 _RESET low: state=IDLE, busy=0, wr=0, addr=0, wdata=0, rdata=0, all counters 0; ramenab/ramwena then follow xbrenab/xbrwena pass-through only.
REQ-036 Reset mid-PEND or mid-CAPT abandons the ARM access with no RAM write; extension pass-through unaffected during and after reset.

Verification
REQ-037 ARM read, idle bus: RAM[15'o12345]=12'o7654, write reg1 {1,0,..,addr 15'o12345} -> ramenab high exactly one clock, reg2 = 12'o7654, busy=0 two clocks after strobe.
REQ-038 ARM write during extension read: xbrenab high 5 clocks, ARM write 12'o1234 to 15'o00100 issued in first -> PEND held 5 clocks, deferrals=5, maxwait=5, then RAM written; extension read data unchanged.
REQ-039 Overrun: two reg1 starts 1 clock apart -> second ignored, overruns=1, first access completes with its own address.
REQ-040 Extension write pass-through: xbrenab=xbrwena=1, xbraddr=15'o70000, xbrwdat=12'o4321 -> same-clock ramaddr/ramwdat match, ramwena=1; ARM PEND idle.
REQ-041 Reg3 clear coincident with deferral increment -> all counters read 0 next clock.
REQ-042 _RESET asserted in PEND -> busy=0 immediately, no ramenab from ARM side afterward.
